fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, rd_clk cycles per serial bit; legal values are 2 or more.
REQ-002 SHALL have parameter width, default 8, data bits per frame; must equal the FIFO word width.
REQ-003 SHALL have port rd_clk  input  1  the single clock, shared with the FIFO read side; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  when high, new frames may start.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  width  FIFO registered read data, valid one cycle after the rd pulse.
REQ-008 SHALL have port fifo_rd  output  1  FIFO read strobe, registered.
REQ-009 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, REQ, LOAD, START, DATA, PARITY (macro only) and STOP.
REQ-012 In IDLE with enable=1 and fifo_empty=0, SHALL set fifo_rd=1 for exactly one cycle and go to REQ; fifo_empty and enable are sampled only in IDLE.
REQ-013 SHALL pass REQ -> LOAD unconditionally and drop fifo_rd to 0.
REQ-014 In LOAD, SHALL capture fifo_data into the shift register, drive tx=0 and go to START; tx falls 2 cycles after fifo_rd rises.
REQ-015 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by the baud counter.
REQ-016 In DATA, SHALL shift out width bits LSB first; the bit counter wraps from width-1 to exit DATA.
REQ-017 SHALL drive tx=1 in STOP, then go to IDLE.
REQ-018 Frame length SHALL be (width+2)*CLKS_PER_BIT cycles.
REQ-019 Back-to-back start bits SHALL be (width+2)*CLKS_PER_BIT+3 cycles apart.
REQ-020 enable falling mid-frame SHALL NOT abort the frame; it blocks only the next REQ.
REQ-021 fifo_empty rising after REQ SHALL be ignored; the byte in flight is sent.
REQ-022 Baud counter width SHALL be $clog2(CLKS_PER_BIT); bit counter width SHALL be $clog2(width)+1.

Reset
REQ-023 While reset=1 at a clock edge: state=IDLE, tx=1, fifo_rd=0, busy=0, counters=0, shift register=0.
REQ-024 Reset mid-frame SHALL abandon the byte, which is lost, with tx=1 from the next edge.
REQ-025 Reset asserted in REQ SHALL still deassert fifo_rd on that edge; no second strobe is issued for the lost byte.

Configuration
REQ-026 With FIFO_UART_TX_PARITY_EN defined, SHALL insert an even-parity bit (XOR of data bits) in PARITY between DATA and STOP, giving a frame of (width+3)*CLKS_PER_BIT cycles.
REQ-027 Without FIFO_UART_TX_PARITY_EN, the PARITY state and its logic SHALL NOT exist, and the frame is as in REQ-018.

Structure
REQ-028 Package fifo_uart_tx_pkg SHALL hold the state enum typedef and the constants START_BIT=0, STOP_BIT=1 and IDLE_LEVEL=1.
REQ-029 Sub-module fifo_uart_tx_baud SHALL contain the CLKS_PER_BIT tick counter, cleared by reset and on LOAD; everything else stays in fifo_uart_tx.

Verification
REQ-030 Reset held 3 cycles -> tx=1, fifo_rd=0, busy=0 on every cycle.
REQ-031 CLKS_PER_BIT=4, FIFO holds 0xA5 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 42 cycles.
REQ-032 CLKS_PER_BIT=4, FIFO holds 0x00 then 0xFF -> 2 fifo_rd pulses; falling edges of the two start bits are 43 cycles apart.
REQ-033 fifo_empty=1, enable=1 for 100 cycles -> fifo_rd never asserts, tx stays 1.
REQ-034 Reset pulsed during data bit 3 of 0x3C -> tx=1 and busy=0 the next cycle; no extra fifo_rd; the next byte is sent intact.
REQ-035 With FIFO_UART_TX_PARITY_EN defined and CLKS_PER_BIT=4, byte 0x07 -> parity bit 1; frame 44 cycles; back-to-back start spacing 47 cycles.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the state enum.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period tick generator: tick is high on the last cycle of every
// CLKS_PER_BIT-cycle window; clear restarts the window at cycle zero.
module fifo_uart_tx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rd_clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a registered-read FIFO.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit before STOP.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int width        = 8
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int BW = $clog2(width) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

  state_t           state_q, state_d;
  logic [width-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             baud_tick;
  logic             baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  fifo_uart_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .rd_clk(rd_clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Handshake: fifo_rd is a one-cycle strobe; fifo_data is taken in LOAD,
  // the cycle after the strobe, and enable/fifo_empty matter only in IDLE.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rd_d       = 1'b0;
    baud_clear = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = IDLE_LEVEL;
        if (enable && !fifo_empty) begin
          rd_d    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d    = fifo_data;
        bit_cnt_d  = '0;
        tx_d       = START_BIT;
        baud_clear = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d   = ^fifo_data;
`endif
        state_d    = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d      = parity_q;
            state_d   = ST_PARITY;
`else
            tx_d      = STOP_BIT;
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          tx_d    = STOP_BIT;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          tx_d    = IDLE_LEVEL;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = IDLE_LEVEL;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LEVEL;
      rd_q      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rd   = rd_q;
  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, width=8 and a
// registered-read FIFO model driven from the stimulus process.
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int W = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic         rd_clk     = 1'b0;
  logic         reset      = 1'b1;
  logic         enable     = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data  = '0;
  logic         fifo_rd;
  logic         tx;
  logic         busy;
  fifo_uart_tx_pkg::state_t dbg_state;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int rd_count = 0;
  logic [W-1:0] exp_q[$];

  always #5 rd_clk = ~rd_clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(C),
    .width       (W)
  ) dut (
    .rd_clk    (rd_clk),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: the FIFO sees the strobe level present before the edge and
  // presents the popped word half a cycle later.
  task automatic tick();
    bit pop;
    pop = (fifo_rd === 1'b1);
    @(posedge rd_clk);
    @(negedge rd_clk);
    cyc++;
    if (pop) begin
      rd_count++;
      if (exp_q.size() > 0) fifo_data = exp_q.pop_front();
      fifo_empty = (exp_q.size() == 0);
    end
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] b);
    logic [NB-1:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) f[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
    f[W+1] = ^b;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic wait_rd();
    int n;
    n = 0;
    while (fifo_rd !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("rd_pulse", fifo_rd, 1);
    check("busy_req", busy, 1);
  endtask

  task automatic run_frame(input logic [W-1:0] b, input bit drop_en, output int fall_cyc);
    logic [NB-1:0] exp_bits;
    int rd0;
    exp_bits = frame_bits(b);
    wait_rd();
    rd0 = rd_count;
    tick();
    check("rd_drop", fifo_rd, 0);
    check("tx_load", tx, 1);
    check("busy_load", busy, 1);
    check("rd_one", rd_count, rd0 + 1);
    tick();
    fall_cyc = cyc;
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < C; c++) begin
        check($sformatf("tx_bit%0d_b%0h", i, b), tx, exp_bits[i]);
        check("busy_frame", busy, 1);
        check("rd_frame", fifo_rd, 0);
        if (drop_en && i == 3 && c == 0) enable = 1'b0;
        tick();
      end
    end
    check("tx_end", tx, 1);
    check("busy_end", busy, 0);
  endtask

  initial begin
    int f0, f1, f2, rd_base;
    @(negedge rd_clk);

    // Reset held three cycles with a byte waiting and enable high.
    reset  = 1'b1;
    enable = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", tx, 1);
      check("rst_rd", fifo_rd, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_state", dbg_state, fifo_uart_tx_pkg::ST_IDLE);
    reset = 1'b0;

    // Single frame 0xA5.
    run_frame(8'hA5, 1'b0, f0);
    check("rd_total_a5", rd_count, 1);

    // Back-to-back 0x00 then 0xFF.
    push(8'h00);
    push(8'hFF);
    run_frame(8'h00, 1'b0, f1);
    run_frame(8'hFF, 1'b0, f2);
    check("b2b_gap", f2 - f1, NB * C + 3);
    check("rd_total_b2b", rd_count, 3);

    // Empty FIFO with enable high: line stays idle.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty_rd", fifo_rd, 0);
      check("empty_tx", tx, 1);
    end
    check("rd_total_empty", rd_count, 3);

    // enable drops mid-frame: frame completes, next byte waits.
    push(8'h5A);
    push(8'h11);
    run_frame(8'h5A, 1'b1, f0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("en_low_rd", fifo_rd, 0);
      check("en_low_busy", busy, 0);
    end
    check("rd_total_en", rd_count, 4);
    enable = 1'b1;
    run_frame(8'h11, 1'b0, f0);
    check("rd_total_en2", rd_count, 5);

    // Reset during data bit 3 of 0x3C.
    push(8'h3C);
    push(8'h81);
    wait_rd();
    tick();
    tick();
    for (int i = 0; i < 4 * C + 1; i++) tick();
    check("mid_bit3", tx, 1);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", fifo_rd, 0);
    reset = 1'b0;
    check("rd_total_mid", rd_count, 6);
    run_frame(8'h81, 1'b0, f0);
    check("rd_total_mid2", rd_count, 7);

    // Reset while the strobe is high: strobe drops, byte is lost.
    push(8'h42);
    push(8'h24);
    wait_rd();
    reset = 1'b1;
    rd_base = rd_count;
    tick();
    check("req_rst_rd", fifo_rd, 0);
    check("req_rst_busy", busy, 0);
    check("req_rst_tx", tx, 1);
    reset = 1'b0;
    run_frame(8'h24, 1'b0, f0);
    check("rd_total_req", rd_count, rd_base + 2);
    check("fifo_drained", exp_q.size(), 0);

    // 0x07: odd number of ones, parity bit 1 when enabled.
    push(8'h07);
    run_frame(8'h07, 1'b0, f0);
    check("rd_total_07", rd_count, rd_base + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
